// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the switch debounce block.
// Imported by the channel sub-module and the top.
package debounce_pkg;

    typedef enum logic {
        ST_STABLE,
        ST_PENDING
    } db_state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;

endpackage : debounce_pkg

// File: rtl/switch_debounce_4_if.sv
// Switch-side bus of the debounce block: raw levels in, conditioned levels,
// change strobes and startup-valid flag out.
interface switch_debounce_4_if #(
    parameter int N_IN = 4
);

    logic [N_IN-1:0] sw_raw;
    logic [N_IN-1:0] sw_clean;
    logic [N_IN-1:0] sw_changed;
    logic            any_changed;
    logic            clean_valid;

    modport master (
        output sw_raw,
        input  sw_clean,
        input  sw_changed,
        input  any_changed,
        input  clean_valid
    );

    modport slave (
        input  sw_raw,
        output sw_clean,
        output sw_changed,
        output any_changed,
        output clean_valid
    );

endinterface : switch_debounce_4_if

// File: rtl/debounce_channel.sv
// One input bit: synchroniser chain, then a stable/pending FSM that accepts a
// new level only after DEBOUNCE_CYCLES consecutive mismatching synced samples.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic changed
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   synced;

    db_state_t        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             cleanNext;
    logic             changedNext;

    // Plain flop chain: any logic between these stages would defeat metastability settling.
    // NOTE: every clocked state update uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncReg <= '0;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = syncReg[SYNC_STAGES-1];

    // NOTE: only the control flops are reset here; there is no memory array to clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_STABLE;
            cnt     <= '0;
            clean   <= 1'b0;
            changed <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            clean   <= cleanNext;
            changed <= changedNext;
        end
    end

    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        cleanNext   = clean;
        changedNext = 1'b0;
        case (state)
            ST_STABLE: begin
                if (synced != clean) begin
                    stateNext = ST_PENDING;
                    cntNext   = CNT_W'(1);
                end else begin
                    cntNext = '0;
                end
            end
            ST_PENDING: begin
                if (synced == clean) begin
                    // Bounce returned to the accepted level before the window closed.
                    stateNext = ST_STABLE;
                    cntNext   = '0;
                end else if (cnt == CNT_LAST) begin
                    stateNext   = ST_STABLE;
                    cntNext     = '0;
                    cleanNext   = synced;
                    changedNext = 1'b1;
                end else begin
                    cntNext = cnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = ST_STABLE;
                cntNext   = '0;
            end
        endcase
    end

endmodule : debounce_channel

// File: rtl/switch_debounce_4.sv
// Conditions N_IN raw switch inputs into clean levels for the 4-input logic gates
// ([3]=inA .. [0]=inD), with per-bit change strobes and a startup-valid flag.
module switch_debounce_4
    import debounce_pkg::*;
#(
    parameter int N_IN            = 4,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input logic                clk,
    input logic                rst_n,
    switch_debounce_4_if.slave bus
);

    localparam int               STARTUP_EDGES = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int               START_W       = $clog2(STARTUP_EDGES + 1);
    localparam logic [START_W-1:0] START_LAST  = START_W'(STARTUP_EDGES - 1);

    logic [N_IN-1:0]    swClean;
    logic [N_IN-1:0]    swChanged;
    logic [START_W-1:0] startCnt;
    logic               cleanValid;

    for (genvar i = 0; i < N_IN; i++) begin : g_channel
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_channel (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (bus.sw_raw[i]),
            .clean   (swClean[i]),
            .changed (swChanged[i])
        );
    end

    // The first accepted level can take the full sync+debounce window, so hold off until then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startCnt   <= '0;
            cleanValid <= 1'b0;
        end else if (!cleanValid) begin
            startCnt <= startCnt + START_W'(1);
            if (startCnt == START_LAST) begin
                cleanValid <= 1'b1;
            end
        end
    end

    assign bus.sw_clean    = swClean;
    assign bus.sw_changed  = swChanged;
    assign bus.any_changed = |swChanged;
    assign bus.clean_valid = cleanValid;

endmodule : switch_debounce_4

// File: tb/tb_switch_debounce_4.sv
// Self-checking bench for switch_debounce_4 (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
// directed scenarios plus randomized toggling against a run-length reference model.
module tb_switch_debounce_4;

    localparam int N_IN = 4;
    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic clk = 1'b0;
    logic clkEn = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 if (clkEn) clk = ~clk;

    switch_debounce_4_if #(.N_IN(N_IN)) ifc ();

    switch_debounce_4 #(
        .N_IN            (N_IN),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // Reference: a bit's accepted level flips once its synced view has
    // disagreed with it for DB edges in a row; the synced view lags raw by SYNC edges.
    logic [N_IN-1:0] mPipe [SYNC];
    logic [N_IN-1:0] mClean;
    logic [N_IN-1:0] mChanged;
    logic            mValid;
    int              mRun [N_IN];
    int              mEdges;

    task automatic modelReset();
        for (int k = 0; k < SYNC; k++) mPipe[k] = '0;
        for (int i = 0; i < N_IN; i++) mRun[i] = 0;
        mClean   = '0;
        mChanged = '0;
        mValid   = 1'b0;
        mEdges   = 0;
    endtask

    task automatic modelEdge(input logic [N_IN-1:0] raw);
        logic [N_IN-1:0] seen;
        seen = mPipe[SYNC-1];
        mChanged = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (seen[i] != mClean[i]) mRun[i]++;
            else mRun[i] = 0;
            if (mRun[i] == DB) begin
                mClean[i]   = seen[i];
                mChanged[i] = 1'b1;
                mRun[i]     = 0;
            end
        end
        for (int k = SYNC - 1; k > 0; k--) mPipe[k] = mPipe[k-1];
        mPipe[0] = raw;
        mEdges++;
        if (mEdges >= SYNC + DB) mValid = 1'b1;
    endtask

    // Drive raw at the falling edge, let one rising edge sample it, settle.
    task automatic tick(input logic [N_IN-1:0] raw);
        @(negedge clk);
        ifc.sw_raw = raw;
        @(posedge clk);
        #1;
        modelEdge(raw);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ifc.sw_raw = 4'hF;
        modelReset();
        #3;
        checks++;
        if ({ifc.sw_clean, ifc.sw_changed, ifc.any_changed, ifc.clean_valid} !== 10'b0) begin
            errors++;
            $display("FAIL reset_no_clock: got clean=%h changed=%h any=%b valid=%b, want all 0",
                     ifc.sw_clean, ifc.sw_changed, ifc.any_changed, ifc.clean_valid);
        end
        clkEn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Release reset with raw=F and verify the startup timing edge by edge.
    task automatic release_and_check(input string tag);
        @(negedge clk);
        rst_n      = 1'b1;
        ifc.sw_raw = 4'hF;
        @(posedge clk);
        #1;
        modelEdge(4'hF);
        for (int e = 1; e <= 7; e++) begin
            if (e > 1) tick(4'hF);
            checks++;
            if (e < 6 && (ifc.sw_clean !== 4'h0 || ifc.clean_valid !== 1'b0)) begin
                errors++;
                $display("FAIL %s_edge%0d: got clean=%h valid=%b, want clean=0 valid=0",
                         tag, e, ifc.sw_clean, ifc.clean_valid);
            end else if (e == 6 && (ifc.sw_clean !== 4'hF || ifc.sw_changed !== 4'hF ||
                                    ifc.clean_valid !== 1'b1 || ifc.any_changed !== 1'b1)) begin
                errors++;
                $display("FAIL %s_edge6: got clean=%h changed=%h valid=%b any=%b, want F F 1 1",
                         tag, ifc.sw_clean, ifc.sw_changed, ifc.clean_valid, ifc.any_changed);
            end else if (e == 7 && (ifc.sw_changed !== 4'h0 || ifc.any_changed !== 1'b0 ||
                                    ifc.clean_valid !== 1'b1 || ifc.sw_clean !== 4'hF)) begin
                errors++;
                $display("FAIL %s_edge7: got clean=%h changed=%h valid=%b any=%b, want F 0 1 0",
                         tag, ifc.sw_clean, ifc.sw_changed, ifc.clean_valid, ifc.any_changed);
            end
        end
    endtask

    task automatic test_clean_step();
        repeat (8) tick(4'h0);
        checks++;
        if (ifc.sw_clean !== 4'h0) begin
            errors++;
            $display("FAIL step_settle: got clean=%h want 0", ifc.sw_clean);
        end
        for (int e = 1; e <= 7; e++) begin
            tick(4'b0001);
            checks++;
            if (e < 6 && (ifc.sw_clean !== 4'h0 || ifc.any_changed !== 1'b0)) begin
                errors++;
                $display("FAIL step_early_edge%0d: got clean=%h any=%b want 0 0", e, ifc.sw_clean, ifc.any_changed);
            end else if (e == 6 && (ifc.sw_clean !== 4'b0001 || ifc.any_changed !== 1'b1 ||
                                    ifc.sw_changed !== 4'b0001)) begin
                errors++;
                $display("FAIL step_edge6: got clean=%h changed=%h any=%b want 1 1 1",
                         ifc.sw_clean, ifc.sw_changed, ifc.any_changed);
            end else if (e == 7 && ifc.any_changed !== 1'b0) begin
                errors++;
                $display("FAIL step_edge7: got any=%b want 0", ifc.any_changed);
            end
        end
    endtask

    task automatic test_glitch();
        for (int e = 0; e < 12; e++) begin
            tick((e < 3) ? 4'b0011 : 4'b0001);
            checks++;
            if (ifc.sw_clean !== 4'b0001 || ifc.sw_changed !== 4'h0) begin
                errors++;
                $display("FAIL glitch_edge%0d: got clean=%h changed=%h want 1 0", e, ifc.sw_clean, ifc.sw_changed);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pattern;
        int pulses;
        int pulseEdge;
        pattern   = 5'b10101;
        pulses    = 0;
        pulseEdge = 0;
        for (int e = 1; e <= 14; e++) begin
            tick((e <= 5) ? {1'b0, pattern[e-1], 2'b01} : 4'b0101);
            if (ifc.sw_changed[2] === 1'b1) begin
                pulses++;
                pulseEdge = e;
            end
        end
        checks++;
        if (pulses != 1 || pulseEdge != 10) begin
            errors++;
            $display("FAIL bounce_pulse: got %0d pulses last at edge %0d, want 1 at edge 10", pulses, pulseEdge);
        end
        checks++;
        if (ifc.sw_clean !== 4'b0101) begin
            errors++;
            $display("FAIL bounce_final: got clean=%h want 5", ifc.sw_clean);
        end
    endtask

    task automatic test_simultaneous();
        repeat (8) tick(4'h0);
        for (int e = 1; e <= 7; e++) begin
            tick(4'b1001);
            checks++;
            if (e == 6 && (ifc.sw_changed !== 4'b1001 || ifc.sw_clean !== 4'b1001)) begin
                errors++;
                $display("FAIL simul_edge6: got clean=%h changed=%h want 9 9", ifc.sw_clean, ifc.sw_changed);
            end else if (e != 6 && ifc.sw_changed !== 4'h0) begin
                errors++;
                $display("FAIL simul_edge%0d: got changed=%h want 0", e, ifc.sw_changed);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (4) tick(4'b1000);
        #2;
        rst_n      = 1'b0;
        ifc.sw_raw = 4'hF;
        modelReset();
        #1;
        checks++;
        if (ifc.sw_clean !== 4'h0 || ifc.clean_valid !== 1'b0 || ifc.sw_changed !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_async: got clean=%h valid=%b changed=%h want 0 0 0",
                     ifc.sw_clean, ifc.clean_valid, ifc.sw_changed);
        end
        repeat (3) @(negedge clk);
        release_and_check("reset_mid");
    endtask

    task automatic test_random();
        logic [N_IN-1:0] raw;
        raw = ifc.sw_raw;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N_IN; i++) begin
                if ($urandom_range(0, 6) == 0) raw[i] = ~raw[i];
            end
            tick(raw);
            checks++;
            if (ifc.sw_clean !== mClean || ifc.sw_changed !== mChanged ||
                ifc.any_changed !== (|mChanged) || ifc.clean_valid !== mValid) begin
                errors++;
                $display("FAIL random_cycle%0d: got clean=%h changed=%h any=%b valid=%b, want %h %h %b %b",
                         c, ifc.sw_clean, ifc.sw_changed, ifc.any_changed, ifc.clean_valid,
                         mClean, mChanged, |mChanged, mValid);
            end
        end
    endtask

    initial begin
        test_reset();
        release_and_check("power_on");
        test_clean_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_switch_debounce_4
